// File: rtl/csa_stream_sched.sv
// CSA stream-layer scheduler: steps the stream-cypher core once per accepted block,
// XORs the core keystream into non-first blocks and owns the control-word register,
// deferring key changes to packet boundaries.
module csa_stream_sched #(
   parameter int unsigned MAX_BLOCKS = 23,
   parameter int unsigned CNT_W      = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [63:0]      ck_in,
   input  logic             ck_load,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_data,
   input  logic             in_first,
   input  logic             in_last,
   input  logic [3:0]       in_bytes,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_data,
   output logic             out_last,
   output logic [3:0]       out_bytes,
   output logic             sc_en,
   output logic             sc_init,
   output logic [63:0]      sc_ck,
   output logic [63:0]      sc_sb,
   input  logic [63:0]      sc_cb,
   output logic             err,
   output logic [CNT_W-1:0] blk_cnt
);

   typedef enum logic [0:0] {StIdle, StActive} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             err_q, err_d;
   logic [63:0]      ck_q, ck_d, shadow_q, shadow_d;
   logic             pend_q, pend_d;
   logic             valid_q, first_q, last_q;
   logic [63:0]      sb_q;
   logic [3:0]       bytes_q;
   logic [63:0]      mask;
   logic             accept, proc, ovf, leave, idle_free;

   assign in_ready = !valid_q | out_ready;
   assign accept   = in_valid & in_ready;

   // Packet FSM: decides whether an accepted beat is processed, counted or flagged.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      proc    = 1'b0;
      ovf     = 1'b0;
      leave   = 1'b0;
      cnt_inc = cnt_q + 1'b1;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (accept) begin
               if (in_first) begin
                  proc    = 1'b1;
                  cnt_d   = CNT_W'(1);
                  leave   = in_last;
                  state_d = in_last ? StIdle : StActive;
               end else begin
                  // Orphan beat outside a packet: swallowed, never reaches the core.
                  err_d = 1'b1;
               end
            end
         end
         StActive: begin
            if (accept) begin
               proc = 1'b1;
               if (in_first) begin
                  // Restart: old packet abandoned, this beat is a fresh init.
                  err_d = 1'b1;
                  cnt_d = CNT_W'(1);
               end else begin
                  cnt_d = cnt_inc;
                  ovf   = !in_last && (cnt_inc == CNT_W'(MAX_BLOCKS));
                  err_d = ovf;
               end
               leave = in_last | ovf;
               if (leave) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control-word handling: direct load when idle, otherwise shadow until the packet ends.
   always_comb begin
      ck_d      = ck_q;
      shadow_d  = shadow_q;
      pend_d    = pend_q;
      idle_free = (state_q == StIdle) && !(proc && in_first);
      if (ck_load) begin
         if (idle_free) begin
            ck_d   = ck_in;
            pend_d = 1'b0;
         end else begin
            shadow_d = ck_in;
            pend_d   = 1'b1;
         end
      end
      if (pend_d && (leave || idle_free)) begin
         ck_d   = shadow_d;
         pend_d = 1'b0;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         ck_q     <= '0;
         shadow_q <= '0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         ck_q     <= ck_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
      end
   end

   // Single output register; holds contents while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         sb_q    <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         bytes_q <= '0;
      end else if (proc) begin
         valid_q <= 1'b1;
         sb_q    <= in_data;
         first_q <= in_first;
         last_q  <= in_last | ovf;
         bytes_q <= in_last ? in_bytes : 4'd8;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   // Keystream applies to the top out_bytes bytes; byte 0 is [63:56].
   always_comb begin
      mask     = ~(64'hFFFF_FFFF_FFFF_FFFF >> {bytes_q, 3'b000});
      out_data = first_q ? sb_q : (sb_q ^ (sc_cb & mask));
   end

   assign out_valid = valid_q;
   assign out_last  = last_q;
   assign out_bytes = bytes_q;
   assign sc_en     = proc;
   assign sc_init   = proc & in_first;
   assign sc_sb     = in_data;
   assign sc_ck     = ck_q;
   assign err       = err_q;
   assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_csa_stream_sched.sv
// Bench for csa_stream_sched: directed scenarios then random traffic, all checked against
// a behavioural packet/key model; the core is modelled as a random keystream source.
module tb_csa_stream_sched;

   localparam int MAXB = 23;

   logic        clk, rst_n;
   logic [63:0] ck_in;
   logic        ck_load;
   logic        in_valid, in_ready, in_first, in_last;
   logic [63:0] in_data;
   logic [3:0]  in_bytes;
   logic        out_valid, out_ready, out_last;
   logic [63:0] out_data;
   logic [3:0]  out_bytes;
   logic        sc_en, sc_init;
   logic [63:0] sc_ck, sc_sb, sc_cb;
   logic        err;
   logic [4:0]  blk_cnt;

   csa_stream_sched #(.MAX_BLOCKS(MAXB), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .ck_in(ck_in), .ck_load(ck_load),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_first(in_first), .in_last(in_last), .in_bytes(in_bytes),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .out_bytes(out_bytes), .sc_en(sc_en), .sc_init(sc_init),
      .sc_ck(sc_ck), .sc_sb(sc_sb), .sc_cb(sc_cb), .err(err), .blk_cnt(blk_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   bit          m_pkt;
   int          m_cnt;
   logic [63:0] m_ck, m_shadow;
   bit          m_pend, m_err, m_ov, m_first, m_last;
   logic [63:0] m_sb, m_cb;
   logic [3:0]  m_bytes;
   bit          cb_force_en;
   logic [63:0] cb_force;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h required %h", tag, obs, exp);
   endtask

   function automatic logic [63:0] ref_out(input logic [63:0] sb, input bit first,
                                           input logic [63:0] cb, input int nb);
      logic [63:0] r;
      r = sb;
      if (!first)
         for (int i = 0; i < 8; i++)
            if (i < nb) r[63-8*i -: 8] = sb[63-8*i -: 8] ^ cb[63-8*i -: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_pkt = 0; m_cnt = 0; m_ck = '0; m_shadow = '0; m_pend = 0; m_err = 0;
      m_ov = 0; m_first = 0; m_last = 0; m_sb = '0; m_cb = '0; m_bytes = '0;
      sc_cb = '0;
   endtask

   // One clock cycle: entered at posedge+1, drives inputs, checks at negedge, commits model.
   task automatic cyc(input bit v, input bit f, input bit l, input int nb,
                      input logic [63:0] d, input bit ordy, input bit ckl,
                      input logic [63:0] cki);
      bit ready, acc, proc, ovf, leave, idle_free, en_seen;
      bit n_pkt, n_pend, n_err;
      int n_cnt;
      logic [63:0] n_ck, n_shadow;
      in_valid = v; in_first = f; in_last = l; in_bytes = 4'(nb); in_data = d;
      out_ready = ordy; ck_load = ckl; ck_in = cki;
      @(negedge clk);
      ready = !m_ov || ordy;
      acc   = v && ready;
      proc  = acc && (f || m_pkt);
      check("in_ready", 64'(in_ready), 64'(ready));
      check("sc_en", 64'(sc_en), 64'(proc));
      check("sc_init", 64'(sc_init), 64'(proc && f));
      if (proc) check("sc_sb", sc_sb, d);
      check("sc_ck", sc_ck, m_ck);
      check("blk_cnt", 64'(blk_cnt), 64'(m_cnt));
      check("err", 64'(err), 64'(m_err));
      check("out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
         check("out_data", out_data, ref_out(m_sb, m_first, m_cb, int'(m_bytes)));
         check("out_last", 64'(out_last), 64'(m_last));
         check("out_bytes", 64'(out_bytes), 64'(m_bytes));
      end
      en_seen = sc_en;
      ovf   = proc && m_pkt && !f && !l && (m_cnt + 1 == MAXB);
      leave = proc && (l || ovf);
      n_err = acc && ((!m_pkt && !f) || (m_pkt && f) || ovf);
      idle_free = !m_pkt && !(proc && f);
      n_ck = m_ck; n_shadow = m_shadow; n_pend = m_pend;
      if (ckl) begin
         if (idle_free) begin n_ck = cki; n_pend = 0; end
         else begin n_shadow = cki; n_pend = 1; end
      end
      if (n_pend && (leave || idle_free)) begin n_ck = n_shadow; n_pend = 0; end
      if (proc) n_cnt = f ? 1 : m_cnt + 1;
      else n_cnt = m_pkt ? m_cnt : 0;
      n_pkt = proc ? !leave : m_pkt;
      @(posedge clk);
      #1;
      if (en_seen) sc_cb = cb_force_en ? cb_force : {$urandom, $urandom};
      if (proc) begin
         m_ov = 1; m_sb = d; m_first = f; m_last = l || ovf;
         m_bytes = l ? 4'(nb) : 4'd8; m_cb = sc_cb;
      end else if (ordy) begin
         m_ov = 0;
      end
      m_pkt = n_pkt; m_cnt = n_cnt; m_err = n_err;
      m_ck = n_ck; m_shadow = n_shadow; m_pend = n_pend;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 8, '0, 1, 0, '0);
   endtask

   task automatic beat(input bit f, input bit l, input int nb, input logic [63:0] d);
      cyc(1, f, l, nb, d, 1, 0, '0);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
   task automatic do_reset();
      in_valid = 0; ck_load = 0;
      #2 rst_n = 0;
      #1;
      check("rst out_valid", 64'(out_valid), 64'd0);
      check("rst out_data", out_data, 64'd0);
      check("rst out_last", 64'(out_last), 64'd0);
      check("rst out_bytes", 64'(out_bytes), 64'd0);
      check("rst sc_ck", sc_ck, 64'd0);
      check("rst err", 64'(err), 64'd0);
      check("rst blk_cnt", 64'(blk_cnt), 64'd0);
      check("rst sc_en", 64'(sc_en), 64'd0);
      model_reset();
      @(negedge clk) rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 0; ck_in = '0; ck_load = 0; in_valid = 0; in_data = '0; in_first = 0;
      in_last = 0; in_bytes = 4'd8; out_ready = 1; cb_force_en = 0; cb_force = '0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Key load while idle, then a clean 3-block packet.
      cyc(0, 0, 0, 8, '0, 1, 1, 64'h0123_4567_89AB_CDEF);
      beat(1, 0, 8, 64'h1111_2222_3333_4444);
      check("first passthrough", out_data, 64'h1111_2222_3333_4444);
      beat(0, 0, 8, 64'h5555_6666_7777_8888);
      beat(0, 1, 8, 64'h9999_AAAA_BBBB_CCCC);
      check("last flag", 64'(out_last), 64'd1);
      idle(2);

      // Partial last block: only the top 3 bytes receive keystream.
      cb_force_en = 1; cb_force = 64'hFFFF_FFFF_FFFF_FFFF;
      beat(1, 0, 8, 64'hDEAD_BEEF_0000_0001);
      beat(0, 1, 3, 64'h0);
      check("bytes3 data", out_data, 64'hFFFF_FF00_0000_0000);
      check("bytes3 count", 64'(out_bytes), 64'd3);
      cb_force_en = 0;
      idle(1);

      // Downstream stall for 4 cycles mid-packet with input still offered.
      beat(1, 0, 8, {$urandom, $urandom});
      beat(0, 0, 8, {$urandom, $urandom});
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8, 64'hABCD_0000_0000_0000, 0, 0, '0);
      beat(0, 0, 8, 64'hABCD_0000_0000_0000);
      beat(0, 1, 5, {$urandom, $urandom});
      idle(2);

      // Orphan beat in idle, then a restart mid-packet.
      beat(0, 0, 8, 64'h7777);
      idle(1);
      beat(1, 0, 8, {$urandom, $urandom});
      beat(0, 0, 8, {$urandom, $urandom});
      beat(1, 0, 8, {$urandom, $urandom});
      check("restart blk_cnt", 64'(blk_cnt), 64'd1);
      beat(0, 1, 8, {$urandom, $urandom});
      idle(2);

      // Overflow: MAXB blocks with no last.
      for (int i = 0; i < MAXB; i++) beat(i == 0, 0, 8, {$urandom, $urandom});
      check("ovf out_last", 64'(out_last), 64'd1);
      check("ovf err", 64'(err), 64'd1);
      check("ovf blk_cnt", 64'(blk_cnt), 64'(MAXB));
      idle(2);

      // Key change mid-packet deferred to the boundary; back-to-back next packet.
      beat(1, 0, 8, {$urandom, $urandom});
      cyc(1, 0, 0, 8, {$urandom, $urandom}, 1, 1, 64'hFEDC_BA98_7654_3210);
      check("key held", sc_ck, 64'h0123_4567_89AB_CDEF);
      beat(0, 0, 8, {$urandom, $urandom});
      beat(0, 1, 8, {$urandom, $urandom});
      check("key applied", sc_ck, 64'hFEDC_BA98_7654_3210);
      beat(1, 0, 8, {$urandom, $urandom});
      beat(0, 1, 2, {$urandom, $urandom});
      idle(1);

      // Reset in the middle of a packet.
      beat(1, 0, 8, {$urandom, $urandom});
      beat(0, 0, 8, {$urandom, $urandom});
      do_reset();

      // Random traffic.
      for (int i = 0; i < 800; i++)
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(1, 8), {$urandom, $urandom},
             $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, {$urandom, $urandom});
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
